// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready 8-bit ALU instruction sequencer (in_valid/in_ready/in_op/in_imm in; out_valid/out_ready/out_data STO port; a_reg/b_reg/carry/zero/busy status)
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] b_reg,
  output logic             carry,
  output logic             zero,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;
  state_t state;
  logic [3:0] op;
  logic [WIDTH-1:0] imm, add_x, add_y, res;
  logic [WIDTH:0] sum;
  logic res_c, wr_c;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == OUT;
  always_comb begin
    add_x = op == 4'hC ? '0 : a_reg;
    add_y = op == 4'h0 ? b_reg : op == 4'h1 ? ~b_reg : ~a_reg;
    sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, op != 4'h0};
    res = a_reg;
    res_c = 1'b0;
    wr_c = 1'b1;
    case (op)
      4'h0, 4'h1, 4'hC: begin res = sum[WIDTH-1:0]; res_c = sum[WIDTH]; end
      4'h2: begin res = a_reg << 1; res_c = a_reg[WIDTH-1]; end
      4'h3: begin res = a_reg >> 1; res_c = a_reg[0]; end
      4'h4: res = a_reg == b_reg ? '0 : a_reg > b_reg ? WIDTH'(1) : '1;
      4'h5: res = a_reg & b_reg;
      4'h6: res = a_reg | b_reg;
      4'h7: res = a_reg ^ b_reg;
      4'h8: res = ~(a_reg & b_reg);
      4'h9: res = ~(a_reg | b_reg);
      4'hA: res = ~(a_reg ^ b_reg);
      4'hB: res = ~a_reg;
      4'hE: begin res = b_reg; wr_c = 1'b0; end
      4'hF: begin res = imm; wr_c = 1'b0; end
      default: wr_c = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      imm <= '0;
      a_reg <= '0;
      b_reg <= '0;
      out_data <= '0;
      carry <= 1'b0;
      zero <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op <= in_op;
          imm <= in_imm;
          state <= EXEC;
        end
        EXEC: if (op == 4'hD) begin
          out_data <= a_reg;
          state <= OUT;
        end else begin
          a_reg <= res;
          zero <= res == '0;
          if (wr_c) carry <= res_c;
          if (op == 4'hE) b_reg <= a_reg;
          state <= IDLE;
        end
        OUT: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] in_op = 4'h0;
  logic [7:0] in_imm = 8'h00;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] out_data, a_reg, b_reg;
  logic carry, zero, busy;
  int checks = 0;
  int failures = 0;
  logic [3:0] lops [7] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
  logic [7:0] lexp [7] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F};
  alu_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .a_reg(a_reg), .b_reg(b_reg), .carry(carry),
    .zero(zero), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_a"}, a_reg, 0);
    chk({tag, "_b"}, b_reg, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_carry"}, carry, 0);
    chk({tag, "_zero"}, zero, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask
  task automatic issue(input logic [3:0] op, input logic [7:0] imm);
    chk("in_ready_before_issue", in_ready, 1);
    in_op = op;
    in_imm = imm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = ~op;
    in_imm = ~imm;
    chk("in_ready_exec", in_ready, 0);
    chk("busy_exec", busy, 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_state("reset");
    issue(4'hF, 8'h05);
    issue(4'hE, 8'h00);
    chk("swp_a", a_reg, 8'h00);
    chk("swp_b", b_reg, 8'h05);
    issue(4'hF, 8'hFB);
    chk("load_ignores_late_imm", a_reg, 8'hFB);
    issue(4'h0, 8'h00);
    chk("add_a", a_reg, 8'h00);
    chk("add_b", b_reg, 8'h05);
    chk("add_carry", carry, 1);
    chk("add_zero", zero, 1);
    issue(4'hF, 8'h03);
    issue(4'h1, 8'h00);
    chk("sub_borrow_a", a_reg, 8'hFE);
    chk("sub_borrow_carry", carry, 0);
    chk("sub_borrow_zero", zero, 0);
    issue(4'h4, 8'h00);
    chk("cmp_gt_a", a_reg, 8'h01);
    chk("cmp_gt_carry", carry, 0);
    issue(4'hF, 8'h02);
    issue(4'h4, 8'h00);
    chk("cmp_lt_a", a_reg, 8'hFF);
    issue(4'hF, 8'h05);
    issue(4'h4, 8'h00);
    chk("cmp_eq_a", a_reg, 8'h00);
    chk("cmp_eq_zero", zero, 1);
    issue(4'hF, 8'h07);
    issue(4'h1, 8'h00);
    chk("sub_noborrow_a", a_reg, 8'h02);
    chk("sub_noborrow_carry", carry, 1);
    issue(4'hF, 8'h81);
    issue(4'h2, 8'h00);
    chk("shl_a", a_reg, 8'h02);
    chk("shl_carry", carry, 1);
    issue(4'h3, 8'h00);
    chk("shr_a", a_reg, 8'h01);
    chk("shr_carry", carry, 0);
    issue(4'hC, 8'h00);
    chk("neg_a", a_reg, 8'hFF);
    chk("neg_carry", carry, 0);
    issue(4'hF, 8'h00);
    issue(4'hC, 8'h00);
    chk("neg0_a", a_reg, 8'h00);
    chk("neg0_carry", carry, 1);
    chk("neg0_zero", zero, 1);
    issue(4'hF, 8'h3C);
    issue(4'hD, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("sto_out_valid", out_valid, 1);
      chk("sto_out_data", out_data, 8'h3C);
      chk("sto_in_ready", in_ready, 0);
      chk("sto_busy", busy, 1);
      @(posedge clk);
      #1;
    end
    chk("sto_keeps_a", a_reg, 8'h3C);
    chk("sto_keeps_carry", carry, 1);
    chk("sto_keeps_zero", zero, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("sto_done_out_valid", out_valid, 0);
    chk("sto_done_in_ready", in_ready, 1);
    chk("sto_done_busy", busy, 0);
    issue(4'hE, 8'h00);
    chk("sweep_b", b_reg, 8'h3C);
    for (int i = 0; i < 7; i++) begin
      issue(4'hF, 8'hFF);
      issue(4'h2, 8'h00);
      chk("sweep_preset_carry", carry, 1);
      issue(4'hF, 8'hF0);
      issue(lops[i], 8'h00);
      chk($sformatf("logic_op%0h_a", lops[i]), a_reg, lexp[i]);
      chk($sformatf("logic_op%0h_carry", lops[i]), carry, 0);
    end
    issue(4'hF, 8'hAA);
    issue(4'hD, 8'h00);
    chk("pre_reset_out_valid", out_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_state("reset_in_out");
    @(posedge clk);
    #1;
    chk("reset_in_out_stays_idle", out_valid, 0);
    in_op = 4'hF;
    in_imm = 8'h77;
    in_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    chk_reset_state("reset_with_valid");
    @(posedge clk);
    #1;
    chk("dropped_instr_a", a_reg, 8'h00);
    chk("dropped_instr_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
